// File: rtl/mext_iter_unit_pkg.sv
// Shared types for the iterative M-extension unit.
//  m_funct3_t    : funct3 encoding of the eight M-extension ops
//  mext_state_t  : control FSM state encoding (IDLE/MUL/DIV/DONE)
//  is_signed_rs1 : op treats rs1 as two's complement
//  is_signed_rs2 : op treats rs2 as two's complement
//  is_div_op     : op uses the divider (DIV/DIVU/REM/REMU)
//  is_rem_op     : op returns the remainder (REM/REMU)
package mext_iter_unit_pkg;

  typedef enum logic [2:0] {
    M_MUL    = 3'b000,
    M_MULH   = 3'b001,
    M_MULHSU = 3'b010,
    M_MULHU  = 3'b011,
    M_DIV    = 3'b100,
    M_DIVU   = 3'b101,
    M_REM    = 3'b110,
    M_REMU   = 3'b111
  } m_funct3_t;

  typedef logic [1:0] mext_state_t;

  localparam mext_state_t ST_IDLE = 2'd0;
  localparam mext_state_t ST_MUL  = 2'd1;
  localparam mext_state_t ST_DIV  = 2'd2;
  localparam mext_state_t ST_DONE = 2'd3;

  function automatic logic is_signed_rs1(input m_funct3_t op);
    case (op)
      M_MUL, M_MULH, M_MULHSU, M_DIV, M_REM: is_signed_rs1 = 1'b1;
      default:                               is_signed_rs1 = 1'b0;
    endcase
  endfunction

  function automatic logic is_signed_rs2(input m_funct3_t op);
    case (op)
      M_MUL, M_MULH, M_DIV, M_REM: is_signed_rs2 = 1'b1;
      default:                     is_signed_rs2 = 1'b0;
    endcase
  endfunction

  function automatic logic is_div_op(input m_funct3_t op);
    is_div_op = op[2];
  endfunction

  function automatic logic is_rem_op(input m_funct3_t op);
    is_rem_op = op[2] & op[1];
  endfunction

endpackage

// File: rtl/mext_restoring_div.sv
// Unsigned restoring divider datapath, one quotient bit per cycle, MSB first.
//  clk, rst          : clock, asynchronous active-low reset
//  start             : load magnitudes and begin XLEN steps
//  flush             : abandon the running division
//  dividend, divisor : unsigned operand magnitudes (sampled on start)
//  quo_nxt, rem_nxt  : quotient/remainder after the current step
//  last              : the current step is the final one
module mext_restoring_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo_nxt,
  output logic [XLEN-1:0] rem_nxt,
  output logic            last
);

  localparam int             CW       = $clog2(XLEN);
  localparam logic [CW-1:0]  CNT_LAST = CW'(XLEN - 1);
  localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dsr_r;
  logic [CW-1:0]   cnt_r;
  logic            run_r;
  logic [XLEN:0]   part_s;
  logic [XLEN:0]   diff_s;
  logic            borrow_s;

  // One restoring step; quo_r doubles as the dividend shift register.
  // Partial remainder stays below 2*divisor, so bit XLEN of the
  // difference is set exactly when the trial subtraction borrows.
  always_comb begin
    part_s   = {rem_r, quo_r[XLEN-1]};
    diff_s   = part_s - {1'b0, dsr_r};
    borrow_s = diff_s[XLEN];
    rem_nxt  = borrow_s ? part_s[XLEN-1:0] : diff_s[XLEN-1:0];
    quo_nxt  = {quo_r[XLEN-2:0], ~borrow_s};
    last     = run_r & (cnt_r == CNT_LAST);
  end

  // Divider state: load on start, drop on flush, step while running
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_r <= {XLEN{1'b0}};
      quo_r <= {XLEN{1'b0}};
      dsr_r <= {XLEN{1'b0}};
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b0;
    end else if (start) begin
      rem_r <= {XLEN{1'b0}};
      quo_r <= dividend;
      dsr_r <= divisor;
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b1;
    end else if (flush) begin
      cnt_r <= {CW{1'b0}};
      run_r <= 1'b0;
    end else if (run_r) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
      cnt_r <= cnt_r + CNT_ONE;
      run_r <= ~last;
    end
  end

endmodule

// File: rtl/mext_iter_unit.sv
// Iterative RV M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
// with valid/ready request and response handshakes and pipeline flush.
//  clk, rst             : clock, asynchronous active-low reset
//  req_valid/req_ready  : request handshake (ready only when idle)
//  req_op               : funct3 of the M op
//  req_rs1, req_rs2     : operands
//  flush                : kill any in-flight op, no response
//  resp_valid/resp_ready: response handshake, result held until taken
//  resp_data            : result, zero while resp_valid is low
//  busy                 : unit is not idle
module mext_iter_unit
  import mext_iter_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic            flush,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_data,
  output logic            busy
);

  localparam int              MUL_CYC  = XLEN / MUL_STEP;
  localparam int              MCW      = $clog2(MUL_CYC);
  localparam int              SHW      = $clog2(2 * XLEN);
  localparam logic [MCW-1:0]  MUL_LAST = MCW'(MUL_CYC - 1);
  localparam logic [MCW-1:0]  MCNT_ONE = MCW'(1);
  localparam logic [XLEN-1:0] ZERO     = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES     = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_INT  = {1'b1, {(XLEN-1){1'b0}}};

  mext_state_t       state_r;
  mext_state_t       state_nxt;
  m_funct3_t         op_s;
  m_funct3_t         op_r;
  logic              s1_s;
  logic              s2_s;
  logic              s1_r;
  logic              s2_r;
  logic [XLEN-1:0]   abs1_s;
  logic [XLEN-1:0]   abs2_s;
  logic              accept_s;
  logic              early_s;
  logic [XLEN-1:0]   early_res_s;
  logic [XLEN-1:0]   mcand_r;
  logic [XLEN-1:0]   mplier_r;
  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] pp_s;
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [2*XLEN-1:0] prod_s;
  logic [MCW-1:0]    mcnt_r;
  logic [SHW-1:0]    msh_s;
  logic              mul_last_s;
  logic [XLEN-1:0]   mul_res_s;
  logic              div_start_s;
  logic              div_last_s;
  logic [XLEN-1:0]   quo_nxt_s;
  logic [XLEN-1:0]   rem_nxt_s;
  logic [XLEN-1:0]   div_res_s;
  logic              load_s;
  logic [XLEN-1:0]   res_s;
  logic [XLEN-1:0]   result_r;
  logic              req_ready_r;
  logic              resp_valid_r;
  logic              busy_r;

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = result_r;
  assign busy       = busy_r;

  // Request decode: operand magnitudes, signs and the RISC-V divide corner cases
  always_comb begin
    op_s   = m_funct3_t'(req_op);
    s1_s   = is_signed_rs1(op_s) & req_rs1[XLEN-1];
    s2_s   = is_signed_rs2(op_s) & req_rs2[XLEN-1];
    abs1_s = s1_s ? -req_rs1 : req_rs1;
    abs2_s = s2_s ? -req_rs2 : req_rs2;
    if (req_rs2 == ZERO) begin
      early_s     = 1'b1;
      early_res_s = is_rem_op(op_s) ? req_rs1 : ONES;
    end else if (is_signed_rs1(op_s) && (req_rs1 == MIN_INT) && (req_rs2 == ONES)) begin
      early_s     = 1'b1;
      early_res_s = is_rem_op(op_s) ? ZERO : MIN_INT;
    end else begin
      early_s     = 1'b0;
      early_res_s = ZERO;
    end
    accept_s    = req_valid & (state_r == ST_IDLE) & ~flush;
    div_start_s = accept_s & is_div_op(op_s) & ~early_s;
  end

  // Multiplier step: add the next MUL_STEP-bit digit's partial product at its weight
  always_comb begin
    pp_s       = {{XLEN{1'b0}}, mcand_r} * {{(2*XLEN-MUL_STEP){1'b0}}, mplier_r[MUL_STEP-1:0]};
    msh_s      = SHW'(mcnt_r) * SHW'(MUL_STEP);
    acc_nxt_s  = acc_r + (pp_s << msh_s);
    prod_s     = (s1_r ^ s2_r) ? -acc_nxt_s : acc_nxt_s;
    mul_res_s  = (op_r == M_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    mul_last_s = (mcnt_r == MUL_LAST);
  end

  // Divide sign fixup: quotient takes s1^s2, remainder follows the dividend
  always_comb begin
    if (is_rem_op(op_r)) begin
      div_res_s = s1_r ? -rem_nxt_s : rem_nxt_s;
    end else begin
      div_res_s = (s1_r ^ s2_r) ? -quo_nxt_s : quo_nxt_s;
    end
  end

  mext_restoring_div #(
    .XLEN(XLEN)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start_s),
    .flush    (flush),
    .dividend (abs1_s),
    .divisor  (abs2_s),
    .quo_nxt  (quo_nxt_s),
    .rem_nxt  (rem_nxt_s),
    .last     (div_last_s)
  );

  // Control FSM next state and the result to latch on entry to DONE
  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    res_s     = ZERO;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_nxt = ST_IDLE;
        end else if (is_div_op(op_s) && early_s) begin
          state_nxt = ST_DONE;
          load_s    = 1'b1;
          res_s     = early_res_s;
        end else if (is_div_op(op_s)) begin
          state_nxt = ST_DIV;
        end else begin
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (mul_last_s) begin
          state_nxt = ST_DONE;
          load_s    = 1'b1;
          res_s     = mul_res_s;
        end else begin
          state_nxt = ST_MUL;
        end
      end
      ST_DIV: begin
        if (flush) begin
          state_nxt = ST_IDLE;
        end else if (div_last_s) begin
          state_nxt = ST_DONE;
          load_s    = 1'b1;
          res_s     = div_res_s;
        end else begin
          state_nxt = ST_DIV;
        end
      end
      ST_DONE: begin
        // flush takes priority over the consumer's handshake
        if (flush || resp_ready) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_DONE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register; status outputs follow the next state so they leave flops directly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nxt;
      req_ready_r  <= (state_nxt == ST_IDLE);
      resp_valid_r <= (state_nxt == ST_DONE);
      busy_r       <= (state_nxt != ST_IDLE);
    end
  end

  // Operand capture at acceptance and multiplier accumulation while in MUL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r     <= M_MUL;
      s1_r     <= 1'b0;
      s2_r     <= 1'b0;
      mcand_r  <= ZERO;
      mplier_r <= ZERO;
      acc_r    <= {(2*XLEN){1'b0}};
      mcnt_r   <= {MCW{1'b0}};
    end else if (accept_s) begin
      op_r     <= op_s;
      s1_r     <= s1_s;
      s2_r     <= s2_s;
      mcand_r  <= abs1_s;
      mplier_r <= abs2_s;
      acc_r    <= {(2*XLEN){1'b0}};
      mcnt_r   <= {MCW{1'b0}};
    end else if ((state_r == ST_MUL) && !flush) begin
      acc_r    <= acc_nxt_s;
      mplier_r <= mplier_r >> MUL_STEP;
      mcnt_r   <= mcnt_r + MCNT_ONE;
    end
  end

  // Result register: loaded on entry to DONE, held there, zero otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_r <= ZERO;
    end else if (load_s) begin
      result_r <= res_s;
    end else if (state_nxt != ST_DONE) begin
      result_r <= ZERO;
    end else begin
      result_r <= result_r;
    end
  end

endmodule

// File: tb/tb_mext_iter_unit.sv
// Self-checking bench for mext_iter_unit: XLEN=32 with MUL_STEP=1 (index 0)
// and MUL_STEP=4 (index 1). Directed table, corner sequences, and random ops
// checked against an arithmetic reference model.
module tb_mext_iter_unit;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic [2:0]  req_op     [2];
  logic [31:0] req_rs1    [2];
  logic [31:0] req_rs2    [2];
  logic        flush      [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_data  [2];
  logic        busy       [2];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  mext_iter_unit #(.XLEN(32), .MUL_STEP(1)) u_dut_s1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_rs1(req_rs1[0]), .req_rs2(req_rs2[0]), .flush(flush[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]),
    .resp_data(resp_data[0]), .busy(busy[0])
  );

  mext_iter_unit #(.XLEN(32), .MUL_STEP(4)) u_dut_s4 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_rs1(req_rs1[1]), .req_rs2(req_rs2[1]), .flush(flush[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]),
    .resp_data(resp_data[1]), .busy(busy[1])
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat1;
    int          lat4;
  } vec_t;

  vec_t tbl [13];

  function automatic int step_of(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s (MUL_STEP=%0d): got %h, expected %h", name, step_of(d), act, exp);
    end
  endtask

  // Reference results straight from the RISC-V M-extension definitions
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      OP_MUL:    begin p = sa * sb; return p[31:0]; end
      OP_MULH:   begin p = sa * sb; return p[63:32]; end
      OP_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      OP_MULHU:  begin up = ua * ub; return up[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      OP_REM: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      OP_DIVU: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input int step);
    if (op < OP_DIV) return 32 / step + 1;
    if (b == 32'd0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Issue one request, check result and latency, optionally hold resp_ready low, then take it
  task automatic run_op(input int d, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input int hold, input string tag);
    int n;
    int lat;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (req_ready[d] !== 1'b1) check({tag, "/ready_timeout"}, d, {31'd0, req_ready[d]}, 32'd1);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_op[d]    = op;
    req_rs1[d]   = a;
    req_rs2[d]   = b;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (resp_valid[d] !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/data"}, d, resp_data[d], exp);
    check({tag, "/latency"}, d, 32'(lat), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, d, {31'd0, resp_valid[d]}, 32'd1);
      check({tag, "/hold_data"}, d, resp_data[d], exp);
      check({tag, "/hold_req_ready"}, d, {31'd0, req_ready[d]}, 32'd0);
    end
    @(negedge clk);
    resp_ready[d] = 1'b1;
    @(posedge clk); #1;
    resp_ready[d] = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int d);
    check({tag, "/req_ready"}, d, {31'd0, req_ready[d]}, 32'd1);
    check({tag, "/resp_valid"}, d, {31'd0, resp_valid[d]}, 32'd0);
    check({tag, "/resp_data"}, d, resp_data[d], 32'd0);
    check({tag, "/busy"}, d, {31'd0, busy[d]}, 32'd0);
  endtask

  // Watch for a response that should never appear
  task automatic expect_silence(input string tag, input int d, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (resp_valid[d] === 1'b1) seen = 1'b1;
    end
    check({tag, "/no_resp"}, d, {31'd0, seen}, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;

    tbl[0]  = '{OP_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 9};
    tbl[1]  = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, 9};
    tbl[2]  = '{OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33, 9};
    tbl[3]  = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 9};
    tbl[4]  = '{OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33, 33};
    tbl[5]  = '{OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33, 33};
    tbl[6]  = '{OP_DIVU,   32'd100,       32'd7,         32'd14,        33, 33};
    tbl[7]  = '{OP_REMU,   32'd100,       32'd7,         32'd2,         33, 33};
    tbl[8]  = '{OP_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF, 1,  1};
    tbl[9]  = '{OP_REMU,   32'd5,         32'd0,         32'd5,         1,  1};
    tbl[10] = '{OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  1};
    tbl[11] = '{OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1,  1};
    tbl[12] = '{OP_MUL,    32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33, 9};

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d]  = 1'b0;
      req_op[d]     = 3'd0;
      req_rs1[d]    = 32'd0;
      req_rs2[d]    = 32'd0;
      flush[d]      = 1'b0;
      resp_ready[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check_idle("in_reset", d);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) check_idle("after_reset", d);

    // Directed table
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 13; i++) begin
        run_op(d, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp,
               (d == 0) ? tbl[i].lat1 : tbl[i].lat4, 0, $sformatf("tbl%0d", i));
      end
    end

    for (int d = 0; d < 2; d++) begin
      // Back-pressure in DONE, then the next request right after the handshake
      run_op(d, OP_DIVU, 32'd100, 32'd7, 32'd14, 33, 5, "hold");
      check("post_handshake/req_ready", d, {31'd0, req_ready[d]}, 32'd1);
      check("post_handshake/resp_valid", d, {31'd0, resp_valid[d]}, 32'd0);
      check("post_handshake/resp_data", d, resp_data[d], 32'd0);
      run_op(d, OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 32 / step_of(d) + 1, 0, "next_req");

      // Flush while idle blocks acceptance
      @(negedge clk);
      req_valid[d] = 1'b1; req_op[d] = OP_DIVU; req_rs1[d] = 32'd50; req_rs2[d] = 32'd5; flush[d] = 1'b1;
      @(posedge clk); #1;
      req_valid[d] = 1'b0; flush[d] = 1'b0;
      check_idle("idle_flush", d);

      // Flush on cycle 10 of a divide
      @(negedge clk);
      req_valid[d] = 1'b1; req_op[d] = OP_DIV; req_rs1[d] = 32'd1000; req_rs2[d] = 32'd3;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      check("div_started/busy", d, {31'd0, busy[d]}, 32'd1);
      repeat (9) @(posedge clk);
      @(negedge clk);
      flush[d] = 1'b1;
      @(posedge clk); #1;
      flush[d] = 1'b0;
      check_idle("div_flush", d);
      expect_silence("div_flush", d, 40);
      run_op(d, OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 0, "after_div_flush");

      // Flush in DONE together with resp_ready drops the response
      @(negedge clk);
      req_valid[d] = 1'b1; req_op[d] = OP_DIV; req_rs1[d] = 32'd5; req_rs2[d] = 32'd0;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      check("done_flush/pre_valid", d, {31'd0, resp_valid[d]}, 32'd1);
      @(negedge clk);
      flush[d] = 1'b1; resp_ready[d] = 1'b1;
      @(posedge clk); #1;
      flush[d] = 1'b0; resp_ready[d] = 1'b0;
      check_idle("done_flush", d);

      // Asynchronous reset in the middle of a multiply
      @(negedge clk);
      req_valid[d] = 1'b1; req_op[d] = OP_MUL; req_rs1[d] = 32'd7; req_rs2[d] = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check_idle("mul_reset", d);
      @(negedge clk);
      rst = 1'b1;
      expect_silence("mul_reset", d, 40);
      run_op(d, OP_DIVU, 32'd9, 32'd3, 32'd3, 33, 0, "after_mul_reset");
    end

    // Random operations against the reference model
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 120; i++) begin
        op = 3'($urandom_range(0, 7));
        a  = pick_operand();
        b  = pick_operand();
        run_op(d, op, a, b, ref_model(op, a, b), ref_lat(op, a, b, step_of(d)),
               0, $sformatf("rand op%0d a=%h b=%h", op, a, b));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
